svm_stream_feeder: RTL and testbench
====================================

# svm_stream_feeder

Upstream stage of the SVM classifier core: turns a command (base word address, word count) into a read-burst on a single-port memory and presents the fetched words as a valid/ready stream that drives the core's `sdata`/`svalid`/`sready` inputs. Firmware issues one command per core interrupt: image, support vector, lambda or bias. A small internal FIFO with credit accounting absorbs backpressure, because the memory read port has fixed latency and cannot stall.

## Interface
- WIDTH, 16: stream and memory data width.
- ADDR_W, 20: memory word-address width.
- LEN_W, 10: command length width (max 1023 words; covers 784-pixel image).
- FIFO_DEPTH, 8: FIFO entries; power of two, ≥ 2.

- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high in IDLE only (and not during abort).
- cmd_addr  in  ADDR_W  base word address.
- cmd_len  in  LEN_W  number of words.
- abort  in  1  synchronous flush/cancel.
- mem_en  out  1  read strobe.
- mem_addr  out  ADDR_W  read address.
- mem_rdata  in  WIDTH  valid exactly 1 cycle after `mem_en`.
- sdata  out  WIDTH  stream data.
- svalid  out  1  stream valid.
- sready  in  1  stream ready from SVM core.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse after last word is transferred.

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE: `cmd_ready`=1. On `cmd_valid` with `cmd_len`≠0: latch addr and len, go to FETCH. With `cmd_len`=0: accept, pulse `done` next cycle, stay IDLE.
- FETCH: issue a read (`mem_en`=1, `mem_addr`=base+index) when `fifo_count + inflight < FIFO_DEPTH`. `inflight` is 0/1 and counts a read issued last cycle. Index increments per read. After the read with index len−1, go to DRAIN.
- Returning `mem_rdata` is written into the FIFO in the cycle it is valid.
- DRAIN: no reads. When FIFO is empty, inflight=0 and the final handshake has occurred, go to IDLE and pulse `done`.
- Stream rule: a transfer occurs on `svalid & sready`. Once `svalid` rises, `sdata` is held stable and `svalid` stays high until the transfer. The only exception is abort.
- Address arithmetic: modulo 2^ADDR_W, so the address wraps at the top of memory without error.
- abort (any state, priority over `cmd_valid`):
  - Next cycle: state IDLE, FIFO emptied, in-flight read data discarded, `svalid`=0.
  - No `done` pulse.
  - `cmd_ready` is 0 in the abort cycle.
- New command arriving in the `done` cycle: accepted normally. Back-to-back bursts are allowed.

## Timing
- Reset values:
  - `mem_en`=0, `mem_addr`=0, `sdata`=0, `svalid`=0, `busy`=0, `done`=0.
  - State IDLE, so `cmd_ready`=1.
- Command accepted at cycle 0 → first `mem_en` in cycle 1 → data enters FIFO at end of cycle 2 → `svalid` high in cycle 3 (registered FIFO output).
- With `sready` held high: one word per cycle sustained. Last handshake at cycle len+2, `done` at cycle len+3.
- Backpressure: with `sready`=0, reads stop once FIFO_DEPTH words are buffered or in flight. No word is ever dropped or duplicated.
- FIFO full and empty are never violated. Simultaneous FIFO write and read at full or empty are legal; occupancy stays unchanged.

## Structure
- Shared package `svm_pkg`:
  - `feeder_state_t` enum.
  - Default WIDTH.
  - `IMG_LEN`=784.
  - Support-vector-count array, shared with the core and the bench.
- One sub-module: `svm_stream_fifo` (synchronous FIFO: parameters WIDTH/DEPTH, count output, registered read data, flush input).
- Top holds the FSM, the address/length counters and the credit logic.

## Test plan
- Reset mid-burst (len=784, reset low at word 300) → all outputs at reset values immediately; a new len=4 command then completes cleanly.
- cmd addr=0x00100, len=784, `sready`=1, memory[a]=a[15:0] → 784 words 0x0100..0x040F in order, `done` at cycle 787.
- Same command, `sready` toggled randomly at 30% duty → identical sequence, no gaps/duplicates; `mem_en` never raised with `fifo_count+inflight`=8.
- cmd len=0 → `done` pulse next cycle, no `mem_en`, `svalid` stays 0.
- cmd addr=0xFFFFE, len=4 → reads 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- abort at word 10 of len=361 with `sready`=0 → next cycle `svalid`=0, `busy`=0, no `done`. A following len=2 command returns only its own 2 words.

Source files
------------

// File: rtl/svm_pkg.sv
// Types and constants shared by the SVM classifier core, its stream feeder and the bench.
package svm_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int IMG_LEN   = 784;
  localparam int N_CLASS   = 4;
  localparam int SV_COUNT [N_CLASS] = '{361, 412, 298, 377};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN
  } feeder_state_t;
endpackage

// File: rtl/svm_stream_fifo.sv
// Synchronous FIFO with a registered output stage; a write into an empty FIFO
// bypasses storage so the word is presented on the very next cycle.
module svm_stream_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] s_cnt_q;
  logic             s_empty, load_out, unload, store;

  // Output register holds one entry, so storage never exceeds DEPTH-1 words.
  assign s_empty  = (s_cnt_q == '0);
  assign load_out = !rd_valid || rd_en;
  assign unload   = load_out && !s_empty;
  assign store    = wr_en && !(load_out && s_empty);
  assign count    = s_cnt_q + CNT_W'(rd_valid);

  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      s_cnt_q  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      s_cnt_q  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (store)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (unload) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      s_cnt_q <= s_cnt_q + CNT_W'(store) - CNT_W'(unload);
      if (load_out) begin
        if (!s_empty) begin
          rd_data  <= mem_q[rd_ptr_q];
          rd_valid <= 1'b1;
        end else if (wr_en) begin
          rd_data  <= wr_data;
          rd_valid <= 1'b1;
        end else begin
          rd_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/svm_stream_feeder.sv
// Turns a (base address, length) command into a fixed-latency memory read burst
// and streams the words out through a credit-limited FIFO.
//
//   state    | meaning
//   ST_IDLE  | waiting for a command, cmd_ready high
//   ST_FETCH | issuing reads while FIFO credit is available
//   ST_DRAIN | all reads issued, waiting for the last handshake
module svm_stream_feeder
  import svm_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_W     = 20,
  parameter int LEN_W      = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              abort,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [WIDTH-1:0]  sdata,
  output logic              svalid,
  input  logic              sready,
  output logic              busy,
  output logic              done
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  feeder_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic              inflight_q, done_q;
  logic [CNT_W-1:0]  fifo_count;
  logic              credit_ok, pop, accept, drain_end;

  assign pop       = svalid && sready;
  assign credit_ok = (fifo_count + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH);
  assign mem_addr  = addr_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    mem_en    = 1'b0;
    accept    = 1'b0;
    drain_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = !abort;
        accept    = cmd_valid && !abort;
        if (accept && cmd_len != '0) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_en = credit_ok && !abort;
        if (mem_en && rem_q == LEN_W'(1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leave in the cycle the final word hands off, so done lands one cycle later.
        if (!inflight_q && !abort &&
            (fifo_count == '0 || (fifo_count == CNT_W'(1) && pop))) begin
          drain_end = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= mem_en;
      done_q     <= (accept && cmd_len == '0) || drain_end;
      if (accept) begin
        addr_q <= cmd_addr;
        rem_q  <= cmd_len;
      end else if (mem_en) begin
        addr_q <= addr_q + ADDR_W'(1);
        rem_q  <= rem_q - LEN_W'(1);
      end
    end
  end

  svm_stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (abort),
    .wr_en    (inflight_q),
    .wr_data  (mem_rdata),
    .rd_en    (pop),
    .rd_data  (sdata),
    .rd_valid (svalid),
    .count    (fifo_count)
  );
endmodule

// File: tb/tb_svm_stream_feeder.sv
// Scoreboard bench for svm_stream_feeder: commands push expected words, a
// negedge monitor pops and compares on every stream handshake.
module tb_svm_stream_feeder;
  import svm_pkg::*;

  localparam int ADDR_W = 20;
  localparam int LEN_W  = 10;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid, cmd_ready, abort, mem_en, svalid, sready, busy, done;
  logic [ADDR_W-1:0] cmd_addr, mem_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [15:0]       mem_rdata, sdata;
  logic              sready_man, sready_rnd, bp_mode;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, acc_cyc = 0, done_cyc = 0, rise_cyc = 0, cmd_done0 = 0;
  int done_cnt = 0, mem_cnt = 0, sv_cnt = 0, words_seen = 0;
  int issued = 0, popped = 0;
  logic        prev_stall = 1'b0, prev_abort = 1'b0, prev_sv = 1'b0;
  logic [15:0] prev_data = '0;
  logic [15:0]       exp_q [$];
  logic [ADDR_W-1:0] addr_log [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sready = bp_mode ? sready_rnd : sready_man;
  always @(posedge clk) begin
    #1;
    sready_rnd = ($urandom_range(0, 99) < 30);
  end

  // Memory with one-cycle read latency; content of word a is a[15:0].
  always @(posedge clk) mem_rdata <= mem_en ? mem_addr[15:0] : 16'hDEAD;

  svm_stream_feeder #(
    .WIDTH(16), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .abort(abort),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .sdata(sdata), .svalid(svalid), .sready(sready),
    .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name, input string what);
    n_checks++;
    $display("FAIL %s: %s", name, what);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0; prev_abort = 1'b0; prev_sv = 1'b0;
      issued = 0; popped = 0;
    end else begin
      if (prev_stall && !prev_abort)
        check("hold", 32'({svalid, sdata}), 32'({1'b1, prev_data}));
      if (svalid && !prev_sv) rise_cyc = cyc;
      if (svalid) sv_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (!busy) begin issued = 0; popped = 0; end
      if (mem_en) begin
        check("credit", 32'((issued - popped) < DEPTH), 32'd1);
        mem_cnt++;
        addr_log.push_back(mem_addr);
        issued++;
      end
      if (svalid && sready) begin
        popped++;
        words_seen++;
        if (exp_q.size() == 0) fail("sb_extra", $sformatf("got word 0x%0h expected none", sdata));
        else check("stream_word", 32'(sdata), 32'(exp_q.pop_front()));
      end
      prev_stall = svalid && !sready;
      prev_data  = sdata;
      prev_abort = abort;
      prev_sv    = svalid;
    end
  end

  task automatic send_cmd(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    int n = 0;
    logic [ADDR_W-1:0] a_i;
    while (!cmd_ready && n < 3000) begin @(posedge clk); #1; n++; end
    if (!cmd_ready) fail("cmd_accept", "cmd_ready never rose");
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
    acc_cyc = cyc; cmd_done0 = done_cnt;
    for (int i = 0; i < int'(l); i++) begin
      a_i = a + ADDR_W'(i);
      exp_q.push_back(a_i[15:0]);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat, input int budget);
    int n = 0;
    while (done_cnt == cmd_done0 && n < budget) begin @(posedge clk); #1; n++; end
    if (done_cnt == cmd_done0) fail(name, "done never pulsed");
    else if (exp_lat >= 0) check(name, 32'(done_cyc - acc_cyc), 32'(exp_lat));
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_words(input int w0, input int target);
    int n = 0;
    while (words_seen - w0 < target && n < 500) begin @(posedge clk); #1; n++; end
    if (words_seen - w0 < target) fail("wait_words", "stream stalled");
  endtask

  logic [ADDR_W-1:0] wrap_addr [4];
  int m0, s0, w0, d0;

  initial begin
    wrap_addr = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; abort = 1'b0;
    sready_man = 1'b0; bp_mode = 1'b0;
    #1 reset = 1'b0;
    #2;
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_sdata", 32'(sdata), 0);
    check("rst_svalid", 32'(svalid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Full image, sready held high
    sready_man = 1'b1; m0 = mem_cnt;
    send_cmd(20'h00100, LEN_W'(IMG_LEN));
    wait_done("img_done_lat", IMG_LEN + 3, 2000);
    check("img_first_valid", 32'(rise_cyc - acc_cyc), 32'd3);
    check("img_reads", 32'(mem_cnt - m0), 32'(IMG_LEN));

    // Same image under random 30% backpressure
    bp_mode = 1'b1; m0 = mem_cnt;
    send_cmd(20'h00100, LEN_W'(IMG_LEN));
    wait_done("bp_done", -1, 8000);
    check("bp_reads", 32'(mem_cnt - m0), 32'(IMG_LEN));
    bp_mode = 1'b0;

    // Zero-length command
    m0 = mem_cnt; s0 = sv_cnt;
    send_cmd(20'h00300, '0);
    wait_done("len0_done_lat", 1, 20);
    repeat (4) begin @(posedge clk); #1; end
    check("len0_no_reads", 32'(mem_cnt - m0), 0);
    check("len0_no_valid", 32'(sv_cnt - s0), 0);

    // Address wrap at top of memory
    addr_log.delete();
    send_cmd(20'hFFFFE, 10'd4);
    wait_done("wrap_done_lat", 7, 50);
    check("wrap_reads", 32'(addr_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      check($sformatf("wrap_addr%0d", i), 32'(addr_log[i]), 32'(wrap_addr[i]));

    // Abort after 10 words of a support-vector burst, stream stalled
    w0 = words_seen;
    send_cmd(20'h02000, LEN_W'(SV_COUNT[0]));
    wait_words(w0, 10);
    sready_man = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    d0 = done_cnt;
    abort = 1'b1;
    #1 check("abort_cmd_ready", 32'(cmd_ready), 0);
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    check("abort_svalid", 32'(svalid), 0);
    check("abort_busy", 32'(busy), 0);
    repeat (5) begin @(posedge clk); #1; end
    check("abort_no_done", 32'(done_cnt - d0), 0);
    sready_man = 1'b1;
    send_cmd(20'h00040, 10'd2);
    wait_done("post_abort_done_lat", 5, 50);

    // Reset in the middle of a full image burst
    w0 = words_seen;
    send_cmd(20'h00100, LEN_W'(IMG_LEN));
    wait_words(w0, 300);
    reset = 1'b0;
    #1;
    check("mid_rst_mem_en", 32'(mem_en), 0);
    check("mid_rst_mem_addr", 32'(mem_addr), 0);
    check("mid_rst_sdata", 32'(sdata), 0);
    check("mid_rst_svalid", 32'(svalid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 1);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    send_cmd(20'h00200, 10'd4);
    wait_done("post_rst_done_lat", 7, 50);

    repeat (3) begin @(posedge clk); #1; end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
